// File: rtl/steer_pkg.sv
// Shared types and helpers for the steering quadrature encoder.
package steer_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  localparam logic [1:0] QUAD_RESET = 2'b00;

  // Next Gray phase: right walks 00->01->11->10->00, left walks it backwards.
  function automatic logic [1:0] quad_next(input logic [1:0] phase, input dir_t dir);
    logic [1:0] nxt;
    nxt = phase;
    case (dir)
      DIR_RIGHT: begin
        case (phase)
          2'b00:   nxt = 2'b01;
          2'b01:   nxt = 2'b11;
          2'b11:   nxt = 2'b10;
          default: nxt = 2'b00;
        endcase
      end
      DIR_LEFT: begin
        case (phase)
          2'b00:   nxt = 2'b10;
          2'b10:   nxt = 2'b11;
          2'b11:   nxt = 2'b01;
          default: nxt = 2'b00;
        endcase
      end
      default: nxt = phase;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/steer_quad_channel.sv
// One steering channel: hold-to-accelerate digital stepping or analog
// position tracking, producing a registered quadrature phase.
module steer_quad_channel
  import steer_pkg::*;
#(
  parameter int MAX_PERIOD = 4,
  parameter int MIN_PERIOD = 1,
  parameter int POSW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            left,
  input  logic            right,
  input  logic            analog_en,
  input  logic [POSW-1:0] target,
  output logic [1:0]      phase,
  output logic            moving
);

  localparam int PW = $clog2(MAX_PERIOD + 1);
  localparam logic [PW-1:0] PERIOD_MAX = PW'(MAX_PERIOD);
  localparam logic [PW-1:0] PERIOD_MIN = PW'(MIN_PERIOD);

  logic [PW-1:0]   wait_q, wait_d;
  logic [PW-1:0]   period_q, period_d;
  logic [PW-1:0]   eff_wait, eff_period, dec_period;
  logic [POSW-1:0] pos_q, pos_d;
  logic [POSW-1:0] diff;
  logic            en_q;
  logic            fresh;
  dir_t            dir_q, dir_now, step_dir;

  // Next-state decision for the current tick (only committed when tick is high).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    dir_now = DIR_NONE;
    if (right && !left)      dir_now = DIR_RIGHT;
    else if (left && !right) dir_now = DIR_LEFT;

    // Modulo difference; its MSB is the sign, so -2**(POSW-1) reads as left.
    diff = target - pos_q;

    // A changed direction or leaving analog mode restarts the hold from scratch.
    fresh      = (dir_now != dir_q) || (en_q && !analog_en);
    eff_wait   = fresh ? '0 : wait_q;
    eff_period = fresh ? PERIOD_MAX : period_q;
    dec_period = (eff_period > PERIOD_MIN) ? eff_period - 1'b1 : PERIOD_MIN;

    wait_d   = wait_q;
    period_d = period_q;
    pos_d    = pos_q;
    step_dir = DIR_NONE;

    if (analog_en && !en_q) begin
      // Entering analog mode: adopt the target as the current position, no jump.
      pos_d    = target;
      wait_d   = '0;
      period_d = PERIOD_MAX;
    end else if (analog_en) begin
      if (wait_q != '0) begin
        wait_d = wait_q - 1'b1;
      end else if (diff != '0) begin
        step_dir = diff[POSW-1] ? DIR_LEFT : DIR_RIGHT;
        pos_d    = diff[POSW-1] ? pos_q - 1'b1 : pos_q + 1'b1;
        wait_d   = PERIOD_MIN - 1'b1;
      end
    end else if (dir_now == DIR_NONE) begin
      wait_d   = '0;
      period_d = PERIOD_MAX;
    end else if (eff_wait == '0) begin
      step_dir = dir_now;
      wait_d   = eff_period - 1'b1;
      period_d = dec_period;
    end else begin
      wait_d   = eff_wait - 1'b1;
      period_d = eff_period;
    end
  end

  // Channel state and registered outputs; moving is a one-cycle step strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q   <= '0;
      period_q <= PERIOD_MAX;
      pos_q    <= '0;
      en_q     <= 1'b0;
      dir_q    <= DIR_NONE;
      phase    <= QUAD_RESET;
      moving   <= 1'b0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments.
      moving <= 1'b0;
      if (tick) begin
        wait_q   <= wait_d;
        period_q <= period_d;
        pos_q    <= pos_d;
        en_q     <= analog_en;
        dir_q    <= dir_now;
        phase    <= quad_next(phase, step_dir);
        moving   <= (step_dir != DIR_NONE);
      end
    end
  end

endmodule

// File: rtl/steer_quad_encoder.sv
// Multi-channel steering quadrature encoder: shared prescaler plus one
// steer_quad_channel per channel, packed onto the steer/moving buses.
module steer_quad_encoder #(
  parameter int NCH        = 2,
  parameter int CLKDIV     = 22500,
  parameter int CNTW       = 16,
  parameter int MAX_PERIOD = 4,
  parameter int MIN_PERIOD = 1,
  parameter int POSW       = 8
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic [NCH-1:0]      left,
  input  logic [NCH-1:0]      right,
  input  logic [NCH-1:0]      analog_en,
  input  logic [NCH*POSW-1:0] target,
  output logic [2*NCH-1:0]    steer,
  output logic [NCH-1:0]      moving
);

  logic [CNTW-1:0] presc_q;
  logic            tick;

  assign tick = (presc_q == CNTW'(CLKDIV - 1));

  // Base-tick prescaler shared by every channel; wraps after CLKDIV cycles.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) presc_q <= '0;
    else          presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : gen_ch
    steer_quad_channel #(
      .MAX_PERIOD (MAX_PERIOD),
      .MIN_PERIOD (MIN_PERIOD),
      .POSW       (POSW)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (Reset_n),
      .tick      (tick),
      .left      (left[i]),
      .right     (right[i]),
      .analog_en (analog_en[i]),
      .target    (target[i*POSW +: POSW]),
      .phase     (steer[2*i+1:2*i]),
      .moving    (moving[i])
    );
  end

endmodule

// File: tb/tb_steer_quad_encoder.sv
// Self-checking bench for steer_quad_encoder with a fast prescaler.
module tb_steer_quad_encoder;

  localparam int NCH        = 2;
  localparam int CLKDIV     = 4;
  localparam int CNTW       = 16;
  localparam int MAX_PERIOD = 4;
  localparam int MIN_PERIOD = 1;
  localparam int POSW       = 8;

  logic                CLK = 1'b0;
  logic                Reset_n = 1'b0;
  logic [NCH-1:0]      left = '0;
  logic [NCH-1:0]      right = '0;
  logic [NCH-1:0]      analog_en = '0;
  logic [NCH*POSW-1:0] target = '0;
  logic [2*NCH-1:0]    steer;
  logic [NCH-1:0]      moving;

  always #5 CLK = ~CLK;

  steer_quad_encoder #(
    .NCH        (NCH),
    .CLKDIV     (CLKDIV),
    .CNTW       (CNTW),
    .MAX_PERIOD (MAX_PERIOD),
    .MIN_PERIOD (MIN_PERIOD),
    .POSW       (POSW)
  ) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .left      (left),
    .right     (right),
    .analog_en (analog_en),
    .target    (target),
    .steer     (steer),
    .moving    (moving)
  );

  typedef struct packed {
    logic [3:0] steer;
    logic [1:0] moving;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_idx[NCH];
  logic [1:0] ring[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Push the expectation for the next tick (s = +1 right, -1 left, 0 none),
  // then run up to that tick's output edge, pop and compare.
  task automatic tick_exp(input string tag, input int s0, input int s1);
    exp_t e;
    exp_idx[0] = (exp_idx[0] + s0 + 4) % 4;
    exp_idx[1] = (exp_idx[1] + s1 + 4) % 4;
    e.steer  = {ring[exp_idx[1]], ring[exp_idx[0]]};
    e.moving = {1'(s1 != 0), 1'(s0 != 0)};
    sb_q.push_back(e);
    repeat (3) @(posedge CLK);
    #1 check({tag, "_pre_moving"}, 32'(moving), 32'd0);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check({tag, "_steer"}, 32'(steer), 32'(e.steer));
    check({tag, "_moving"}, 32'(moving), 32'(e.moving));
  endtask

  // Hold a direction on one channel for n ticks; step gaps shrink
  // MAX_PERIOD, MAX_PERIOD-1, ... down to MIN_PERIOD.
  task automatic accel_ticks(input string tag, input int ch, input int dir, input int n);
    int next_step = 1;
    int gap = MAX_PERIOD;
    for (int t = 1; t <= n; t++) begin
      int s = 0;
      if (t == next_step) begin
        s = dir;
        next_step += gap;
        gap = (gap - 1 > MIN_PERIOD) ? gap - 1 : MIN_PERIOD;
      end
      tick_exp(tag, (ch == 0) ? s : 0, (ch == 1) ? s : 0);
    end
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int t = 0; t < n; t++) tick_exp(tag, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_idx[0] = 0;
    exp_idx[1] = 0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_steer", 32'(steer), 32'd0);
    check("rst_moving", 32'(moving), 32'd0);
    Reset_n = 1'b1;

    // 1: hold right on channel 0, accelerating steps at ticks 1,5,8,10,11,12
    right[0] = 1'b1;
    accel_ticks("t1", 0, 1, 12);
    right[0] = 1'b0;
    idle_ticks("t1_rel", 1);

    // 2: left on channel 1 for 3 steps, release 2 ticks, then right restarts at a 4-tick gap
    left[1] = 1'b1;
    accel_ticks("t2_left", 1, -1, 8);
    left[1] = 1'b0;
    idle_ticks("t2_rel", 2);
    right[1] = 1'b1;
    accel_ticks("t2_right", 1, 1, 5);
    right[1] = 1'b0;
    idle_ticks("t2_rel2", 1);

    // 3: both directions together means no movement
    left[0]  = 1'b1;
    right[0] = 1'b1;
    idle_ticks("t3_both", 20);
    left[0]  = 1'b0;
    right[0] = 1'b0;

    // 4: analog tracking: adopt 10, then 13 (3 right), then 250 (19 left)
    analog_en[0]   = 1'b1;
    target[7:0]    = 8'd10;
    idle_ticks("t4_enter", 1);
    target[7:0] = 8'd13;
    for (int i = 0; i < 3; i++) tick_exp("t4_up", 1, 0);
    idle_ticks("t4_hold13", 1);
    target[7:0] = 8'd250;
    for (int i = 0; i < 19; i++) tick_exp("t4_down", -1, 0);
    idle_ticks("t4_hold250", 2);

    // 5: re-enter at 254, wrap to 2 (4 right), then half-range distance goes left
    analog_en[0] = 1'b0;
    idle_ticks("t5_exit", 1);
    analog_en[0] = 1'b1;
    target[7:0]  = 8'd254;
    idle_ticks("t5_enter", 1);
    target[7:0] = 8'd2;
    for (int i = 0; i < 4; i++) tick_exp("t5_wrap", 1, 0);
    idle_ticks("t5_at2", 1);
    target[7:0] = 8'd130;
    tick_exp("t5_half", -1, 0);
    target[7:0] = 8'd1;
    idle_ticks("t5_at1", 1);
    analog_en[0] = 1'b0;
    idle_ticks("t5_exit2", 1);

    // 6: reset during a tick cycle mid-acceleration, then the hold restarts
    right[0] = 1'b1;
    accel_ticks("t6_pre", 0, 1, 7);
    repeat (3) @(posedge CLK);
    #2 Reset_n = 1'b0;
    #1;
    check("t6_async_steer", 32'(steer), 32'd0);
    check("t6_async_moving", 32'(moving), 32'd0);
    repeat (2) @(negedge CLK);
    check("t6_held_steer", 32'(steer), 32'd0);
    exp_idx[0] = 0;
    exp_idx[1] = 0;
    Reset_n = 1'b1;
    accel_ticks("t6_post", 0, 1, 5);
    right[0] = 1'b0;
    idle_ticks("t6_rel", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
